// File: rtl/mem_pkg.sv
// Shared encodings for the load/store engine: funct3 widths, fault causes, FSM states.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    CauseNone       = 2'b00,
    CauseMisaligned = 2'b01,
    CauseIllegal    = 2'b10,
    CauseTimeout    = 2'b11
  } cause_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBus  = 2'b01,
    StResp = 2'b10
  } state_e;

endpackage

// File: rtl/lane_align.sv
// Combinational byte-lane steering: store data/mask placement, load shift and extension,
// plus misaligned and illegal-width detection.
module lane_align
  import mem_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  localparam int unsigned NB = XLEN / 8,
  localparam int unsigned OFF_W = $clog2(NB)
) (
  input  logic             is_write,
  input  logic [2:0]       funct3,
  input  logic [OFF_W-1:0] off,
  input  logic [XLEN-1:0]  wdata,
  input  logic [XLEN-1:0]  rdata,
  output logic [NB-1:0]    mask,
  output logic [XLEN-1:0]  wdata_steer,
  output logic [XLEN-1:0]  rdata_ext,
  output logic             misaligned,
  output logic             illegal
);

  logic [3:0]      nbytes;
  logic [15:0]     size_ones;
  logic [XLEN-1:0] shifted_w;
  logic [XLEN-1:0] shifted_r;
  logic [XLEN-1:0] lane_bits;

  // Lane mask, alignment and legality of the access width.
  always_comb begin
    nbytes     = 4'd1 << funct3[1:0];
    size_ones  = (16'd1 << nbytes) - 16'd1;
    mask       = NB'(size_ones << off);
    // Size is a power of two, so off mod size is just the low bits of off.
    misaligned = (off & OFF_W'(nbytes - 4'd1)) != '0;
    if (is_write) begin
      illegal = funct3[2];
    end else begin
      illegal = (funct3 == 3'b111) || ((XLEN == 32) && ((funct3 == F3_D) || (funct3 == F3_WU)));
    end
  end

  // Store data moved to its lanes; lanes outside the mask forced to zero.
  always_comb begin
    lane_bits = '0;
    shifted_w = wdata << {off, 3'b000};
    for (int i = 0; i < NB; i++) begin
      lane_bits[8*i +: 8] = {8{mask[i]}};
    end
    wdata_steer = shifted_w & lane_bits;
  end

  // Load data shifted down to bit 0 then sign- or zero-extended by width.
  always_comb begin
    shifted_r = rdata >> {off, 3'b000};
    case (funct3)
      F3_B:    rdata_ext = XLEN'($signed(shifted_r[7:0]));
      F3_H:    rdata_ext = XLEN'($signed(shifted_r[15:0]));
      F3_W:    rdata_ext = XLEN'($signed(shifted_r[31:0]));
      F3_BU:   rdata_ext = XLEN'(shifted_r[7:0]);
      F3_HU:   rdata_ext = XLEN'(shifted_r[15:0]);
      F3_WU:   rdata_ext = XLEN'(shifted_r[31:0]);
      default: rdata_ext = shifted_r;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store engine between the core control FSM and the system bus, with handshakes,
// lane steering, fault detection and a bus wait-state timeout.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                rsp_valid,
  output logic [XLEN-1:0]     rsp_rdata,
  output logic                rsp_fault,
  output logic [1:0]          rsp_cause,
  output logic                bus_valid,
  input  logic                bus_ready,
  output logic                bus_write,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [XLEN-1:0]     bus_wdata,
  output logic [XLEN/8-1:0]   bus_byteMask,
  input  logic [XLEN-1:0]     bus_rdata
);

  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Counter value at which the next unanswered BUS cycle expires the request.
  localparam logic [CNT_W-1:0] CntLast =
      CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : int'(TIMEOUT_CYCLES) - 1);

  state_e            state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic              write_q, write_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bus_valid_q, bus_valid_d;
  logic              bus_write_q, bus_write_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [XLEN-1:0]   bus_wdata_q, bus_wdata_d;
  logic [NB-1:0]     bus_mask_q, bus_mask_d;
  logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic              rsp_fault_q, rsp_fault_d;
  cause_e            rsp_cause_q, rsp_cause_d;

  logic              la_write;
  logic [2:0]        la_funct3;
  logic [OFF_W-1:0]  la_off;
  logic [NB-1:0]     la_mask;
  logic [XLEN-1:0]   la_wdata;
  logic [XLEN-1:0]   la_rdata;
  logic              la_misaligned;
  logic              la_illegal;

  // One aligner serves both phases: live request in IDLE, captured request afterwards.
  always_comb begin
    if (state_q == StIdle) begin
      la_write  = req_write;
      la_funct3 = req_funct3;
      la_off    = req_addr[OFF_W-1:0];
    end else begin
      la_write  = write_q;
      la_funct3 = funct3_q;
      la_off    = off_q;
    end
  end

  lane_align #(
    .XLEN(XLEN)
  ) u_lane_align (
    .is_write   (la_write),
    .funct3     (la_funct3),
    .off        (la_off),
    .wdata      (req_wdata),
    .rdata      (bus_rdata),
    .mask       (la_mask),
    .wdata_steer(la_wdata),
    .rdata_ext  (la_rdata),
    .misaligned (la_misaligned),
    .illegal    (la_illegal)
  );

  // Next-state, capture and response logic for the IDLE/BUS/RESP sequence.
  always_comb begin
    state_d     = state_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    write_d     = write_q;
    cnt_d       = cnt_q;
    bus_valid_d = bus_valid_q;
    bus_write_d = bus_write_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_mask_d  = bus_mask_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_fault_d = rsp_fault_q;
    rsp_cause_d = rsp_cause_q;
    req_ready   = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          funct3_d    = req_funct3;
          off_d       = req_addr[OFF_W-1:0];
          write_d     = req_write;
          cnt_d       = '0;
          rsp_rdata_d = '0;
          if (la_illegal) begin
            state_d     = StResp;
            rsp_fault_d = 1'b1;
            rsp_cause_d = CauseIllegal;
          end else if (la_misaligned) begin
            state_d     = StResp;
            rsp_fault_d = 1'b1;
            rsp_cause_d = CauseMisaligned;
          end else begin
            state_d     = StBus;
            bus_valid_d = 1'b1;
            bus_write_d = req_write;
            bus_addr_d  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            bus_wdata_d = req_write ? la_wdata : '0;
            bus_mask_d  = la_mask;
          end
        end
      end
      StBus: begin
        // A handshake in the limit cycle still completes normally.
        if (bus_ready) begin
          state_d     = StResp;
          bus_valid_d = 1'b0;
          rsp_fault_d = 1'b0;
          rsp_cause_d = CauseNone;
          rsp_rdata_d = write_q ? '0 : la_rdata;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CntLast)) begin
          state_d     = StResp;
          bus_valid_d = 1'b0;
          cnt_d       = '0;
          rsp_fault_d = 1'b1;
          rsp_cause_d = CauseTimeout;
          rsp_rdata_d = '0;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StResp: begin
        state_d     = StIdle;
        rsp_rdata_d = '0;
        rsp_fault_d = 1'b0;
        rsp_cause_d = CauseNone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      funct3_q    <= '0;
      off_q       <= '0;
      write_q     <= 1'b0;
      cnt_q       <= '0;
      bus_valid_q <= 1'b0;
      bus_write_q <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_mask_q  <= '0;
      rsp_rdata_q <= '0;
      rsp_fault_q <= 1'b0;
      rsp_cause_q <= CauseNone;
    end else begin
      state_q     <= state_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      write_q     <= write_d;
      cnt_q       <= cnt_d;
      bus_valid_q <= bus_valid_d;
      bus_write_q <= bus_write_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_mask_q  <= bus_mask_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_fault_q <= rsp_fault_d;
      rsp_cause_q <= rsp_cause_d;
    end
  end

  assign rsp_valid    = (state_q == StResp);
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_fault    = rsp_fault_q;
  assign rsp_cause    = rsp_cause_q;
  assign bus_valid    = bus_valid_q;
  assign bus_write    = bus_write_q;
  assign bus_addr     = bus_addr_q;
  assign bus_wdata    = bus_wdata_q;
  assign bus_byteMask = bus_mask_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench: a 32-bit unit (default timeout) and a 64-bit unit (timeout of 3).
module tb_mem_access_unit;

  typedef struct packed {
    logic [63:0] rdata;
    logic        fault;
    logic [1:0]  cause;
  } rsp_exp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [63:0] wdata;
    logic [7:0]  mask;
  } bus_exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid [2];
  logic        bus_ready [2];
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [63:0] bus_rdata;

  logic        req_ready_a, rsp_valid_a, rsp_fault_a, bus_valid_a, bus_write_a;
  logic [31:0] rsp_rdata_a, bus_addr_a, bus_wdata_a;
  logic [1:0]  rsp_cause_a;
  logic [3:0]  bus_mask_a;
  logic        req_ready_b, rsp_valid_b, rsp_fault_b, bus_valid_b, bus_write_b;
  logic [63:0] rsp_rdata_b, bus_wdata_b;
  logic [31:0] bus_addr_b;
  logic [1:0]  rsp_cause_b;
  logic [7:0]  bus_mask_b;

  // Index 0 = 32-bit unit, 1 = 64-bit unit.
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic        rsp_fault [2];
  logic [1:0]  rsp_cause [2];
  logic [63:0] rsp_rdata [2];
  logic        bus_valid [2];
  logic        bus_write [2];
  logic [31:0] bus_addr  [2];
  logic [63:0] bus_wdata [2];
  logic [7:0]  bus_mask  [2];

  assign req_ready[0] = req_ready_a;
  assign rsp_valid[0] = rsp_valid_a;
  assign rsp_fault[0] = rsp_fault_a;
  assign rsp_cause[0] = rsp_cause_a;
  assign rsp_rdata[0] = {32'h0, rsp_rdata_a};
  assign bus_valid[0] = bus_valid_a;
  assign bus_write[0] = bus_write_a;
  assign bus_addr[0]  = bus_addr_a;
  assign bus_wdata[0] = {32'h0, bus_wdata_a};
  assign bus_mask[0]  = {4'h0, bus_mask_a};
  assign req_ready[1] = req_ready_b;
  assign rsp_valid[1] = rsp_valid_b;
  assign rsp_fault[1] = rsp_fault_b;
  assign rsp_cause[1] = rsp_cause_b;
  assign rsp_rdata[1] = rsp_rdata_b;
  assign bus_valid[1] = bus_valid_b;
  assign bus_write[1] = bus_write_b;
  assign bus_addr[1]  = bus_addr_b;
  assign bus_wdata[1] = bus_wdata_b;
  assign bus_mask[1]  = bus_mask_b;

  mem_access_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYCLES(255)) dut32 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready_a),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata[31:0]), .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a),
    .rsp_fault(rsp_fault_a), .rsp_cause(rsp_cause_a), .bus_valid(bus_valid_a),
    .bus_ready(bus_ready[0]), .bus_write(bus_write_a), .bus_addr(bus_addr_a),
    .bus_wdata(bus_wdata_a), .bus_byteMask(bus_mask_a), .bus_rdata(bus_rdata[31:0])
  );

  mem_access_unit #(.XLEN(64), .ADDR_W(32), .TIMEOUT_CYCLES(3)) dut64 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready_b),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b),
    .rsp_fault(rsp_fault_b), .rsp_cause(rsp_cause_b), .bus_valid(bus_valid_b),
    .bus_ready(bus_ready[1]), .bus_write(bus_write_b), .bus_addr(bus_addr_b),
    .bus_wdata(bus_wdata_b), .bus_byteMask(bus_mask_b), .bus_rdata(bus_rdata)
  );

  int errors = 0;
  int checks = 0;

  rsp_exp_t rq0[$], rq1[$];
  bus_exp_t bq0[$], bq1[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: byte-by-byte view of the access rules.
  task automatic model(input int sel, input bit wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                       input int waits, output rsp_exp_t r, output bus_exp_t b,
                       output bit on_bus, output int lat, output int bcyc);
    int xl, nbb, tmo, nb, off;
    bit illegal;
    xl  = (sel != 0) ? 64 : 32;
    nbb = xl / 8;
    tmo = (sel != 0) ? 3 : 255;
    nb  = 1 << f3[1:0];
    off = int'(addr % nbb);
    r = '0; b = '0; on_bus = 0; lat = 1; bcyc = 0;
    illegal = wr ? f3[2] : ((f3 == 3'b111) || (xl == 32 && (f3 == 3'b011 || f3 == 3'b110)));
    if (illegal) begin
      r.fault = 1'b1; r.cause = 2'b10;
    end else if ((off % nb) != 0) begin
      r.fault = 1'b1; r.cause = 2'b01;
    end else begin
      on_bus = 1;
      b.addr = addr - 32'(off);
      b.wr   = wr;
      for (int i = 0; i < nbb; i++) begin
        if (i >= off && i < off + nb) begin
          b.mask[i] = 1'b1;
          b.wdata[8*i +: 8] = wd[8*(i-off) +: 8];
        end
      end
      if (waits >= tmo) begin
        r.fault = 1'b1; r.cause = 2'b11; lat = 1 + tmo; bcyc = tmo;
      end else begin
        lat = 2 + waits; bcyc = waits + 1;
        if (!wr) begin
          for (int i = 0; i < nb; i++) r.rdata[8*i +: 8] = rd[8*(off+i) +: 8];
          if (!f3[2] && r.rdata[8*nb-1]) begin
            for (int j = 8*nb; j < xl; j++) r.rdata[j] = 1'b1;
          end
        end
      end
    end
  endtask

  // Drives one request, plays the bus slave with `waits` wait states, checks timing.
  task automatic issue(input int sel, input bit wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                       input int waits);
    rsp_exp_t r;
    bus_exp_t b;
    bit on_bus;
    int exp_lat, exp_bc, lat, bc, n;
    model(sel, wr, f3, addr, wd, rd, waits, r, b, on_bus, exp_lat, exp_bc);
    if (sel == 0) rq0.push_back(r); else rq1.push_back(r);
    if (on_bus) begin
      if (sel == 0) bq0.push_back(b); else bq1.push_back(b);
    end
    n = 0;
    while (req_ready[sel] !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready", 64'(req_ready[sel]), 64'd1);
    req_write      = wr;
    req_funct3     = f3;
    req_addr       = addr;
    req_wdata      = wd;
    bus_rdata      = rd;
    req_valid[sel] = 1'b1;
    @(negedge clk);
    req_valid[sel] = 1'b0;
    lat = 1;
    bc  = 0;
    while (rsp_valid[sel] !== 1'b1 && lat < 64) begin
      if (bus_valid[sel] === 1'b1) bc++;
      bus_ready[sel] = (lat > waits);
      @(negedge clk);
      lat++;
    end
    bus_ready[sel] = 1'b0;
    chk("rsp_latency", 64'(lat), 64'(exp_lat));
    chk("bus_valid_cycles", 64'(bc), 64'(exp_bc));
    chk("bus_valid_in_resp", 64'(bus_valid[sel]), 64'd0);
  endtask

  // Monitor: response scoreboard, bus request contents, and bus signal stability.
  logic        pv_valid [2];
  logic        pv_write [2];
  logic [31:0] pv_addr  [2];
  logic [63:0] pv_wdata [2];
  logic [7:0]  pv_mask  [2];

  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (rsp_valid[s] === 1'b1) begin
        if ((s == 0 && rq0.size() == 0) || (s == 1 && rq1.size() == 0)) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: unit %0d got rsp_valid=1 expected none", s);
        end else begin
          rsp_exp_t e;
          e = (s == 0) ? rq0.pop_front() : rq1.pop_front();
          chk("rsp_rdata", rsp_rdata[s], e.rdata);
          chk("rsp_fault", 64'(rsp_fault[s]), 64'(e.fault));
          chk("rsp_cause", 64'(rsp_cause[s]), 64'(e.cause));
        end
      end
      if (bus_valid[s] === 1'b1 && !pv_valid[s]) begin
        if ((s == 0 && bq0.size() == 0) || (s == 1 && bq1.size() == 0)) begin
          checks++;
          errors++;
          $display("FAIL bus_unexpected: unit %0d got bus_valid=1 expected 0", s);
        end else begin
          bus_exp_t e;
          e = (s == 0) ? bq0.pop_front() : bq1.pop_front();
          chk("bus_addr", 64'(bus_addr[s]), 64'(e.addr));
          chk("bus_write", 64'(bus_write[s]), 64'(e.wr));
          chk("bus_byteMask", 64'(bus_mask[s]), 64'(e.mask));
          if (e.wr) chk("bus_wdata", bus_wdata[s], e.wdata);
        end
      end else if (bus_valid[s] === 1'b1) begin
        chk("bus_stable", 64'((bus_addr[s] === pv_addr[s]) && (bus_write[s] === pv_write[s]) &&
            (bus_wdata[s] === pv_wdata[s]) && (bus_mask[s] === pv_mask[s])), 64'd1);
      end
      pv_valid[s] = (bus_valid[s] === 1'b1);
      pv_write[s] = bus_write[s];
      pv_addr[s]  = bus_addr[s];
      pv_wdata[s] = bus_wdata[s];
      pv_mask[s]  = bus_mask[s];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_exp_t rb;
    logic [2:0]  f3;
    logic [63:0] wd, rd;
    bit          wr;
    reset        = 1'b0;
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    bus_ready[0] = 1'b0; bus_ready[1] = 1'b0;
    req_write = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0; bus_rdata = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("reset_req_ready", 64'(req_ready[s]), 64'd1);
      chk("reset_rsp_valid", 64'(rsp_valid[s]), 64'd0);
      chk("reset_rsp_rdata", rsp_rdata[s], 64'd0);
      chk("reset_bus_valid", 64'(bus_valid[s]), 64'd0);
      chk("reset_bus_addr", 64'(bus_addr[s]), 64'd0);
      chk("reset_bus_mask", 64'(bus_mask[s]), 64'd0);
      chk("reset_bus_wdata", bus_wdata[s], 64'd0);
    end
    reset = 1'b1;
    @(negedge clk);

    // 32-bit directed cases.
    issue(0, 0, 3'b000, 32'h1003, 64'h0, 64'h80FF_FF12, 0);
    issue(0, 0, 3'b100, 32'h1003, 64'h0, 64'h80FF_FF12, 0);
    issue(0, 1, 3'b001, 32'h2002, 64'hDEAD_BEEF, 64'h0, 0);
    issue(0, 0, 3'b010, 32'h1002, 64'h0, 64'h0, 0);
    issue(0, 1, 3'b100, 32'h1000, 64'h1234, 64'h0, 0);
    issue(0, 0, 3'b010, 32'h4000, 64'h0, 64'hCAFE_F00D, 5);
    issue(0, 0, 3'b011, 32'h4000, 64'h0, 64'h0, 0);
    issue(0, 0, 3'b110, 32'h4000, 64'h0, 64'h0, 0);
    issue(0, 0, 3'b111, 32'h4000, 64'h0, 64'h0, 0);
    issue(0, 0, 3'b101, 32'h4002, 64'h0, 64'h8001_7FFF, 1);

    // Reset during BUS drops the request with no response.
    rb = '0; rb.addr = 32'h3000; rb.mask = 8'h0F;
    bq0.push_back(rb);
    while (req_ready[0] !== 1'b1) @(negedge clk);
    req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h3000; req_valid[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("pre_reset_bus_valid", 64'(bus_valid[0]), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_bus_valid", 64'(bus_valid[0]), 64'd0);
    chk("post_reset_rsp_valid", 64'(rsp_valid[0]), 64'd0);
    chk("post_reset_req_ready", 64'(req_ready[0]), 64'd1);
    reset = 1'b1;
    issue(0, 1, 3'b000, 32'h5001, 64'hA5, 64'h0, 0);

    // 64-bit directed cases (timeout limit 3).
    issue(1, 0, 3'b011, 32'h10, 64'h0, 64'h8000_0000_0000_0001, 0);
    issue(1, 0, 3'b110, 32'h14, 64'h0, 64'hFFFF_FFFF_1234_5678, 0);
    issue(1, 0, 3'b010, 32'h18, 64'h0, 64'h8765_4321_0000_0000, 2);
    issue(1, 1, 3'b011, 32'h20, 64'h0123_4567_89AB_CDEF, 64'h0, 100);
    issue(1, 0, 3'b000, 32'h27, 64'h0, 64'hFF00_0000_0000_0000, 3);
    issue(1, 1, 3'b011, 32'h24, 64'h1, 64'h0, 0);

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      wr = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if (wr && f3 == 3'b011) f3 = 3'b010;
      wd = {$urandom, $urandom};
      rd = {$urandom, $urandom};
      issue(0, wr, f3, $urandom, wd, rd, int'($urandom_range(0, 5)));
    end
    for (int k = 0; k < 25; k++) begin
      wr = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      wd = {$urandom, $urandom};
      rd = {$urandom, $urandom};
      issue(1, wr, f3, $urandom, wd, rd, int'($urandom_range(0, 4)));
    end

    repeat (4) @(negedge clk);
    chk("rsp_queue_drained", 64'(rq0.size() + rq1.size()), 64'd0);
    chk("bus_queue_drained", 64'(bq0.size() + bq1.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised load/store engine between the multicycle core's control FSM and the system bus.
- Replaces the fixed 4-bit byte mask and unconditioned memory path with four capabilities:
  - ready/valid handshakes on both sides
  - byte-lane steering of write data, and load shifting with sign/zero extension
  - misaligned/illegal access detection
  - bus wait-state tolerance with timeout.
- Supports 32- or 64-bit data paths.

Parameters:
- XLEN, 32, data width; legal values 32 or 64.
- ADDR_W, 32, address width.
- TIMEOUT_CYCLES, 255, maximum number of BUS-state cycles before a timeout fault; 0 disables the timeout.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  core presents an access.
- req_ready  out  1  unit can accept an access.
- req_write  in  1  1=store, 0=load.
- req_funct3  in  3  RISC-V width/sign encoding.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  XLEN  extended load data; 0 for stores and faults.
- rsp_fault  out  1  access failed.
- rsp_cause  out  2  01=misaligned, 10=illegal funct3, 11=timeout, 00=none.
- bus_valid  out  1  bus request.
- bus_ready  in  1  bus accepts (write) or returns data (read).
- bus_write  out  1  bus write strobe.
- bus_addr  out  ADDR_W  req_addr with the low log2(XLEN/8) bits cleared.
- bus_wdata  out  XLEN  lane-steered store data.
- bus_byteMask  out  XLEN/8  active byte lanes.
- bus_rdata  in  XLEN  read data, sampled when bus_valid && bus_ready.

Behaviour:
- Reset: sampled at a clk edge with reset==0.
  - State goes to IDLE.
  - All registered outputs go to 0: rsp_*, bus_valid, bus_write, bus_addr, bus_wdata, bus_byteMask.
  - Timeout counter goes to 0.
  - Reset overrides everything, including mid-transaction; an aborted bus request is dropped without waiting for bus_ready.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, capture the request.
  - If the request is illegal or misaligned, go to RESP with fault; bus_valid never rises.
  - Otherwise go to BUS with bus_* outputs registered.
- BUS:
  - bus_valid=1; bus_addr, bus_write, bus_wdata and bus_byteMask stay stable until handshake.
  - On bus_ready: sample bus_rdata and go to RESP.
  - Timeout counter increments each BUS cycle without bus_ready. On reaching TIMEOUT_CYCLES: drop bus_valid, go to RESP with cause 11.
  - bus_ready in the same cycle as the count limit: the handshake wins.
- RESP:
  - rsp_valid=1 for exactly one cycle, then return to IDLE.
  - req_ready=0 in RESP and BUS.
- Latency: accept at edge k; BUS during cycle k+1; with zero wait states, rsp_valid is high during cycle k+2. Each bus wait state adds one cycle. Minimum issue interval is 3 cycles.
- Size and offset:
  - size = 1/2/4/8 bytes for funct3[1:0] = 00/01/10/11.
  - off = req_addr[log2(XLEN/8)-1:0].
  - Misaligned when off mod size != 0.
- Illegal funct3:
  - Store: funct3[2]=1.
  - Load: 111, and 011/110 when XLEN=32.
  - Illegal takes priority over misaligned.
- Store lane steering:
  - bus_byteMask = ((1<<size)-1) << off.
  - bus_wdata = req_wdata << 8*off; lanes outside the mask are don't-care but driven 0.
- Load lane steering:
  - shifted = bus_rdata >> 8*off.
  - Sign-extend for 000/001/010 (LB/LH/LW) and 011 (LD).
  - Zero-extend for 100/101/110 (LBU/LHU/LWU).
  - For loads, bus_byteMask = ((1<<size)-1) << off (informational).
- Store completion: rsp_rdata=0 on successful stores.

Decomposition:
- Package mem_pkg:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU)
  - fault-cause enum
  - FSM state enum.
- Sub-module lane_align, purely combinational:
  - inputs XLEN, funct3, off, wdata, rdata
  - outputs mask, steered wdata, extended rdata, misaligned, illegal.
- The FSM, capture registers and timeout counter stay in mem_access_unit.

Test Plan:
- XLEN=32, load funct3=000, addr=0x1003, bus_rdata=0x80FF_FF12, bus_ready same cycle -> bus_addr=0x1000, mask=1000, rsp_rdata=0xFFFF_FF80, rsp_valid 2 cycles after accept; repeat with funct3=100 -> 0x0000_0080.
- Store funct3=001, addr=0x2002, wdata=0xDEAD_BEEF -> bus_byteMask=1100, bus_wdata=0xBEEF_0000, bus_write=1, rsp_rdata=0, rsp_fault=0.
- Load funct3=010, addr=0x1002 -> rsp_fault=1, rsp_cause=01, bus_valid stays 0 throughout; store funct3=100 -> rsp_cause=10.
- bus_ready held low 5 cycles -> bus_* outputs stable for 6 cycles, rsp_valid on the cycle after the handshake; with TIMEOUT_CYCLES=3 and bus_ready never asserted -> bus_valid drops after 3 cycles, rsp_cause=11, rsp_rdata=0.
- reset=0 asserted during BUS -> next cycle state IDLE, bus_valid=0, no rsp_valid; a new request is accepted immediately after reset=1.
- XLEN=64, funct3=011, addr=0x10, bus_rdata=0x8000_0000_0000_0001 -> mask=0xFF, rsp_rdata equal to bus_rdata; funct3=110 at addr 0x14 with upper word 0xFFFF_FFFF -> rsp_rdata=0x0000_0000_FFFF_FFFF.
